pcie_lcrc_stream: RTL and testbench
===================================

Name: pcie_lcrc_stream

Overview:
- Sequential, parametrised CRC-32 engine that computes the LCRC over a TLP streamed in DATA_W-bit beats.
- Replaces fixed-width, single-shot combinational CRC evaluation.
- Sits in the TX DLL between the sequence-number/TLP framing stage and the LCRC append stage.
- Adds packet framing (sop/eop), a partial last beat, a registered result with backpressure, and protocol-error reporting.

Parameters:
- DATA_W, 32: beat width in bits; multiple of 8, 8..256.
- POLY, 32'h04C11DB7: generator polynomial.
- INIT, 32'hFFFFFFFF: running CRC value loaded at each sop.
- XOR_OUT, 32'h00000000: value XORed into the final CRC before output.
- LEN_W, 13: width of the byte-count output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  DATA_W  beat payload; byte k = in_data[8k+7:8k]
- in_sop  in  1  first beat of packet
- in_eop  in  1  last beat of packet
- in_keep  in  DATA_W/8  valid-byte mask; sampled on eop beats only
- crc_valid  out  1  result valid
- crc_ready  in  1  result consumed when crc_valid && crc_ready
- crc_data  out  32  final CRC (running CRC ^ XOR_OUT)
- crc_len  out  LEN_W  packet byte count
- err_o  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Outputs: crc_valid=0, crc_data=0, crc_len=0, err_o=0.
  - Internals: state=IDLE, running CRC=INIT, byte counter=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-packet discards the packet and any pending result; no error is flagged.
- in_ready is combinational: in_ready = !crc_valid || crc_ready. The input stalls only while an unconsumed result is held.
- Bit processing, per accepted valid byte, in ascending byte order, bit 0 of each byte first:
  - fb = crc[31] ^ d
  - crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0)
  - The whole beat is unrolled combinationally in a single cycle. Throughput is 1 beat/clk.
- Byte validity:
  - Non-eop beats: all DATA_W/8 bytes are valid; in_keep is ignored.
  - eop beats: in_keep must be nonzero and contiguous from bit 0 (e.g. 4'b0111).
- State IDLE:
  - Beat with sop: start a packet. The CRC is seeded with INIT and then updated with this beat.
  - Beat with sop and eop together: single-beat packet.
  - Beat without sop: dropped; err_o pulses the next cycle; remain in IDLE.
- State ACCUM:
  - Beat without sop and without eop: update the CRC; byte count += DATA_W/8.
  - Beat with eop: finalise and return to IDLE.
  - Beat with sop: the current packet is aborted with no result; err_o pulses; a new packet starts from INIT with this beat.
- Finalise on the eop beat:
  - The cycle after acceptance: crc_valid=1, crc_data=CRC^XOR_OUT, crc_len=total valid bytes. Latency is 1 clk from the eop handshake.
  - crc_data and crc_len hold stable until crc_ready.
  - If crc_ready=1 in the same cycle that a new eop is accepted, the new result replaces the old one with no bubble.
- Illegal in_keep on an eop beat (zero or non-contiguous): packet dropped, err_o pulses, no result, return to IDLE.
- Byte counter saturates at 2^LEN_W-1. Saturation is not an error.
- Beats with in_valid=0 or in_ready=0 change no state.

Test Plan:
- DATA_W=32, one beat in_data=32'hFFFFFFFF, keep=4'hF, sop=eop=1 -> 1 clk later crc_valid=1, crc_data=32'h00000000, crc_len=4.
- Same stimulus with XOR_OUT=32'hFFFFFFFF -> crc_data=32'hFFFFFFFF, crc_len=4.
- DATA_W=32, 3-beat packet of 11 bytes (last keep=4'b0111) with random data; repeat at DATA_W=64 and 128 for the same byte stream -> crc_data matches the bitwise software model (same bit order, INIT, POLY, XOR_OUT) and is identical across widths; crc_len=11.
- Result held with crc_ready=0 for 5 clks while the next packet is offered -> in_ready=0, crc_data stable; crc_ready=1 releases in_ready the same cycle; back-to-back eops with crc_ready=1 give no lost result.
- Protocol errors:
  - Beat without sop in IDLE -> err_o 1-cycle pulse, no crc_valid.
  - sop mid-packet -> err_o pulse, only the second packet's CRC is output.
  - eop keep=4'b0000 or 4'b0101 -> err_o pulse, no result.
- rst asserted mid-packet and while crc_valid=1 -> the next cycle crc_valid=0, crc_len=0; the following packet's CRC equals its standalone model value.

Source files
------------

// File: rtl/pcie_lcrc_stream.sv
// Streaming LCRC-32 engine for the TX data link layer: accumulates a CRC over
// sop/eop-framed TLP beats and presents a registered result with backpressure.
module pcie_lcrc_stream #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'h00000000,
  parameter int          LEN_W   = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [DATA_W/8-1:0] in_keep,
  output logic                crc_valid,
  input  logic                crc_ready,
  output logic [31:0]         crc_data,
  output logic [LEN_W-1:0]    crc_len,
  output logic                err_o
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_crc, w_crc_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_crc_valid, w_crc_valid_nxt;
  logic [31:0]        r_crc_data, w_crc_data_nxt;
  logic [LEN_W-1:0]   r_crc_len, w_crc_len_nxt;
  logic               r_err, w_err_nxt;

  logic               w_accept;
  logic               w_restart;
  logic               w_keep_ok;
  logic [31:0]        w_seed_crc;
  logic [LEN_W-1:0]   w_seed_cnt;
  logic [31:0]        w_beat_crc;
  logic [CW-1:0]      w_nbytes;
  logic [LEN_W:0]     w_sum;
  logic [LEN_W-1:0]   w_beat_cnt;

  // One byte, LSB first, MSB-first shift register form.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    logic        fb;
    v = c;
    for (int i = 0; i < 8; i++) begin
      fb = v[31] ^ d[i];
      v  = {v[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return v;
  endfunction

  assign in_ready  = !r_crc_valid || crc_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_restart = (r_state == S_IDLE) || in_sop;
  assign w_keep_ok = (in_keep != '0) && ((in_keep & (in_keep + NB'(1))) == '0);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    w_seed_crc = w_restart ? INIT : r_crc;
    w_seed_cnt = w_restart ? '0 : r_cnt;
    w_beat_crc = w_seed_crc;
    w_nbytes   = '0;
    for (int k = 0; k < NB; k++) begin
      if (!in_eop || in_keep[k]) begin
        // NOTE: blocking assignments here chain the bytes through one cycle of logic.
        w_beat_crc = crc_byte(w_beat_crc, in_data[8*k +: 8]);
        w_nbytes   = w_nbytes + CW'(1);
      end
    end
    w_sum      = {1'b0, w_seed_cnt} + (LEN_W+1)'(w_nbytes);
    w_beat_cnt = w_sum[LEN_W] ? '1 : w_sum[LEN_W-1:0];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_cnt_nxt       = r_cnt;
    w_crc_valid_nxt = r_crc_valid && !crc_ready;
    w_crc_data_nxt  = r_crc_data;
    w_crc_len_nxt   = r_crc_len;
    w_err_nxt       = 1'b0;
    if (w_accept) begin
      if (in_sop || r_state == S_ACCUM) begin
        // A sop inside a packet aborts it; the new beat still starts a packet.
        if (in_sop && r_state == S_ACCUM) w_err_nxt = 1'b1;
        if (in_eop) begin
          w_state_nxt = S_IDLE;
          w_crc_nxt   = INIT;
          w_cnt_nxt   = '0;
          if (w_keep_ok) begin
            w_crc_valid_nxt = 1'b1;
            w_crc_data_nxt  = w_beat_crc ^ XOR_OUT;
            w_crc_len_nxt   = w_beat_cnt;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_ACCUM;
          w_crc_nxt   = w_beat_crc;
          w_cnt_nxt   = w_beat_cnt;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crc       <= INIT;
      r_cnt       <= '0;
      r_crc_valid <= 1'b0;
      r_crc_data  <= '0;
      r_crc_len   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_crc_valid <= w_crc_valid_nxt;
      r_crc_data  <= w_crc_data_nxt;
      r_crc_len   <= w_crc_len_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign crc_valid = r_crc_valid;
  assign crc_data  = r_crc_data;
  assign crc_len   = r_crc_len;
  assign err_o     = r_err;

endmodule

// File: tb/tb_pcie_lcrc_stream.sv
// Directed self-checking bench for pcie_lcrc_stream at 32, 64 and 128-bit beats.
module tb_pcie_lcrc_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crc_ready = 1'b0;

  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic        in_ready, crc_valid, err_o;
  logic [31:0] crc_data;
  logic [12:0] crc_len;

  logic        x_ready, x_valid, x_err;
  logic [31:0] x_data;
  logic [12:0] x_len;

  logic         v64 = 1'b0, s64 = 1'b0, e64 = 1'b0;
  logic [63:0]  d64 = '0;
  logic [7:0]   k64 = '0;
  logic         r64, cv64, er64;
  logic [31:0]  cd64;
  logic [12:0]  cl64;

  logic         v128 = 1'b0, s128 = 1'b0, e128 = 1'b0;
  logic [127:0] d128 = '0;
  logic [15:0]  k128 = '0;
  logic         r128, cv128, er128;
  logic [31:0]  cd128;
  logic [12:0]  cl128;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] pkt [0:31];

  always #5 clk = ~clk;

  pcie_lcrc_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_keep(in_keep), .crc_valid(crc_valid),
    .crc_ready(crc_ready), .crc_data(crc_data), .crc_len(crc_len), .err_o(err_o));

  pcie_lcrc_stream #(.XOR_OUT(32'hFFFFFFFF)) dut_x (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_keep(in_keep), .crc_valid(x_valid),
    .crc_ready(crc_ready), .crc_data(x_data), .crc_len(x_len), .err_o(x_err));

  pcie_lcrc_stream #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_data(d64),
    .in_sop(s64), .in_eop(e64), .in_keep(k64), .crc_valid(cv64),
    .crc_ready(crc_ready), .crc_data(cd64), .crc_len(cl64), .err_o(er64));

  pcie_lcrc_stream #(.DATA_W(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(v128), .in_ready(r128), .in_data(d128),
    .in_sop(s128), .in_eop(e128), .in_keep(k128), .crc_valid(cv128),
    .crc_ready(crc_ready), .crc_data(cd128), .crc_len(cl128), .err_o(er128));

  // Bit-serial reference over pkt[0..n-1], bit 0 of each byte first.
  function automatic logic [31:0] model_crc(input int n, input logic [31:0] xo);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ pkt[i][j];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    return c ^ xo;
  endfunction

  function automatic logic [31:0] pack32(input int s);
    return {pkt[s+3], pkt[s+2], pkt[s+1], pkt[s]};
  endfunction

  task automatic fill(input int n, input int seed);
    for (int k = 0; k < 32; k++) pkt[k] = (k < n) ? 8'(seed + k * 59) : 8'hEE;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [31:0] d, input logic [3:0] keep);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL send_ready got=%b exp=1", in_ready);
    end
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d; in_keep = keep;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send64(input logic sop, input logic eop, input logic [63:0] d, input logic [7:0] keep);
    v64 = 1'b1; s64 = sop; e64 = eop; d64 = d; k64 = keep;
    @(posedge clk); #1;
    v64 = 1'b0; s64 = 1'b0; e64 = 1'b0;
  endtask

  task automatic send128(input logic sop, input logic eop, input logic [127:0] d, input logic [15:0] keep);
    v128 = 1'b1; s128 = sop; e128 = eop; d128 = d; k128 = keep;
    @(posedge clk); #1;
    v128 = 1'b0; s128 = 1'b0; e128 = 1'b0;
  endtask

  task automatic consume();
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", crc_valid); end
    n_checks++; if (crc_data !== 32'h0) begin n_errors++; $display("FAIL reset_data got=%h exp=0", crc_data); end
    n_checks++; if (crc_len !== 13'd0) begin n_errors++; $display("FAIL reset_len got=%0d exp=0", crc_len); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_ones();
    send(1'b1, 1'b1, 32'hFFFFFFFF, 4'hF);
    n_checks++; if (crc_valid !== 1'b1) begin n_errors++; $display("FAIL ones_valid got=%b exp=1", crc_valid); end
    n_checks++; if (crc_data !== 32'h00000000) begin n_errors++; $display("FAIL ones_data got=%h exp=00000000", crc_data); end
    n_checks++; if (crc_len !== 13'd4) begin n_errors++; $display("FAIL ones_len got=%0d exp=4", crc_len); end
    n_checks++; if (x_data !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL ones_xor_data got=%h exp=FFFFFFFF", x_data); end
    n_checks++; if (x_len !== 13'd4) begin n_errors++; $display("FAIL ones_xor_len got=%0d exp=4", x_len); end
    consume();
    n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL ones_release got=%b exp=0", crc_valid); end
  endtask

  task automatic test_widths();
    logic [31:0]  exp;
    logic [63:0]  b64;
    logic [127:0] b128;
    fill(11, 8'h5A);
    exp = model_crc(11, 32'h0);
    send(1'b1, 1'b0, pack32(0), 4'h0);
    send(1'b0, 1'b0, pack32(4), 4'h0);
    send(1'b0, 1'b1, pack32(8), 4'b0111);
    n_checks++; if (crc_data !== exp) begin n_errors++; $display("FAIL w32_data got=%h exp=%h", crc_data, exp); end
    n_checks++; if (crc_len !== 13'd11) begin n_errors++; $display("FAIL w32_len got=%0d exp=11", crc_len); end
    consume();
    b64 = {pack32(4), pack32(0)};
    send64(1'b1, 1'b0, b64, 8'h00);
    b64 = {pack32(12), pack32(8)};
    send64(1'b0, 1'b1, b64, 8'b0000_0111);
    n_checks++; if (cd64 !== exp) begin n_errors++; $display("FAIL w64_data got=%h exp=%h", cd64, exp); end
    n_checks++; if (cl64 !== 13'd11) begin n_errors++; $display("FAIL w64_len got=%0d exp=11", cl64); end
    consume();
    b128 = {pack32(12), pack32(8), pack32(4), pack32(0)};
    send128(1'b1, 1'b1, b128, 16'h07FF);
    n_checks++; if (cd128 !== exp) begin n_errors++; $display("FAIL w128_data got=%h exp=%h", cd128, exp); end
    n_checks++; if (cl128 !== 13'd11) begin n_errors++; $display("FAIL w128_len got=%0d exp=11", cl128); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_b;
    send(1'b1, 1'b1, 32'hFFFFFFFF, 4'hF);
    fill(4, 8'h13);
    exp_b = model_crc(4, 32'h0);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = pack32(0); in_keep = 4'hF;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, in_ready); end
      n_checks++; if (crc_data !== 32'h0) begin n_errors++; $display("FAIL bp_hold[%0d] got=%h exp=0", c, crc_data); end
      @(posedge clk); #1;
    end
    crc_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; crc_ready = 1'b0;
    n_checks++; if (crc_valid !== 1'b1) begin n_errors++; $display("FAIL bp_next_valid got=%b exp=1", crc_valid); end
    n_checks++; if (crc_data !== exp_b) begin n_errors++; $display("FAIL bp_next_data got=%h exp=%h", crc_data, exp_b); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_c, exp_d, dc, dd;
    fill(4, 8'h21); exp_c = model_crc(3, 32'h0); dc = pack32(0);
    fill(4, 8'h77); exp_d = model_crc(4, 32'h0); dd = pack32(0);
    crc_ready = 1'b1;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = dc; in_keep = 4'b0111;
    @(posedge clk); #1;
    n_checks++; if (crc_data !== exp_c || crc_len !== 13'd3) begin n_errors++; $display("FAIL b2b_first got=%h/%0d exp=%h/3", crc_data, crc_len, exp_c); end
    in_data = dd; in_keep = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    n_checks++; if (crc_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid got=%b exp=1", crc_valid); end
    n_checks++; if (crc_data !== exp_d || crc_len !== 13'd4) begin n_errors++; $display("FAIL b2b_second got=%h/%0d exp=%h/4", crc_data, crc_len, exp_d); end
    @(posedge clk); #1;
    crc_ready = 1'b0;
    n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b exp=0", crc_valid); end
  endtask

  task automatic test_err_nosop();
    send(1'b0, 1'b0, 32'hDEADBEEF, 4'hF);
    n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL nosop_err got=%b exp=1", err_o); end
    n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL nosop_valid got=%b exp=0", crc_valid); end
    @(posedge clk); #1;
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL nosop_pulse got=%b exp=0", err_o); end
    n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL nosop_valid2 got=%b exp=0", crc_valid); end
  endtask

  task automatic test_err_sop_mid();
    logic [31:0] exp;
    send(1'b1, 1'b0, 32'hCAFEF00D, 4'h0);
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL sopmid_early got=%b exp=0", err_o); end
    fill(6, 8'h40);
    exp = model_crc(6, 32'h0);
    send(1'b1, 1'b0, pack32(0), 4'h0);
    n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL sopmid_err got=%b exp=1", err_o); end
    send(1'b0, 1'b1, pack32(4), 4'b0011);
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL sopmid_pulse got=%b exp=0", err_o); end
    n_checks++; if (crc_data !== exp) begin n_errors++; $display("FAIL sopmid_data got=%h exp=%h", crc_data, exp); end
    n_checks++; if (crc_len !== 13'd6) begin n_errors++; $display("FAIL sopmid_len got=%0d exp=6", crc_len); end
    consume();
  endtask

  task automatic test_err_keep();
    logic [3:0] bad [2] = '{4'b0000, 4'b0101};
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 1'b0, 32'h01020304, 4'hF);
      send(1'b0, 1'b1, 32'h05060708, bad[i]);
      n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL keep_err[%b] got=%b exp=1", bad[i], err_o); end
      n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL keep_valid[%b] got=%b exp=0", bad[i], crc_valid); end
      @(posedge clk); #1;
      n_checks++; if (crc_valid !== 1'b0) begin n_errors++; $display("FAIL keep_valid2[%b] got=%b exp=0", bad[i], crc_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    send(1'b1, 1'b0, 32'h11111111, 4'hF);
    pulse_rst();
    n_checks++; if (crc_valid !== 1'b0 || crc_len !== 13'd0 || err_o !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_state got=%b/%0d/%b exp=0/0/0", crc_valid, crc_len, err_o); end
    fill(4, 8'h99);
    exp = model_crc(4, 32'h0);
    send(1'b0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    send(1'b1, 1'b1, pack32(0), 4'hF);
    n_checks++; if (crc_data !== exp) begin n_errors++; $display("FAIL rstmid_next got=%h exp=%h", crc_data, exp); end
    pulse_rst();
    n_checks++; if (crc_valid !== 1'b0 || crc_len !== 13'd0 || crc_data !== 32'h0) begin
      n_errors++; $display("FAIL rstvalid_state got=%b/%0d/%h exp=0/0/0", crc_valid, crc_len, crc_data); end
    fill(8, 8'h0C);
    exp = model_crc(7, 32'h0);
    send(1'b1, 1'b0, pack32(0), 4'h0);
    send(1'b0, 1'b1, pack32(4), 4'b0111);
    n_checks++; if (crc_data !== exp || crc_len !== 13'd7) begin
      n_errors++; $display("FAIL rstvalid_next got=%h/%0d exp=%h/7", crc_data, crc_len, exp); end
    consume();
  endtask

  task automatic test_saturation();
    send(1'b1, 1'b0, 32'h0, 4'h0);
    in_valid = 1'b1; in_data = 32'h0;
    repeat (2047) @(posedge clk);
    #1 in_valid = 1'b0;
    send(1'b0, 1'b1, 32'h0, 4'hF);
    n_checks++; if (crc_valid !== 1'b1) begin n_errors++; $display("FAIL sat_valid got=%b exp=1", crc_valid); end
    n_checks++; if (crc_len !== 13'h1FFF) begin n_errors++; $display("FAIL sat_len got=%0d exp=8191", crc_len); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL sat_err got=%b exp=0", err_o); end
    consume();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_ones();
    test_widths();
    test_backpressure();
    test_back_to_back();
    test_err_nosop();
    test_err_sop_mid();
    test_err_keep();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
